matriz_controlador: RTL and testbench
=====================================

MATRIZ_CONTROLADOR -- requirements
Module: matriz_controlador

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have start (in, 1): request to execute one instruction, sampled only in IDLE.
REQ-004 SHALL have opcode (in, 4), escalar (in, 8), base_a, base_b, base_c (in, 8 each): instruction fields, captured on the accepted start.
REQ-005 SHALL have busy (out, 1), finished (out, 1, one-cycle pulse) and erro (out, 1, sticky until next accepted start).
REQ-006 SHALL have the memory port mem_addr (out, 8), mem_rdata (in, 8; synchronous read, 1-cycle latency), mem_wdata (out, 8) and mem_we (out, 1).
REQ-007 SHALL have the ALU port alu_opcode (out, 4), alu_escalar (out, 8), alu_matrizA and alu_matrizB (out, 200 each), alu_resultado (in, 200) and alu_done (in, 1).

Function
REQ-008 SHALL pack element (i,j), i,j in 0..4, as signed 8 bits at bits 8*(5i+j), stored at memory address base+5i+j modulo 256 (wrap-around allowed).
REQ-009 SHALL implement the states IDLE, LOAD_A, LOAD_B, EXEC, STORE, DONE and ERR.
REQ-010 IDLE: start=1 with a valid opcode (0011..1100) SHALL latch the fields, set busy, clear erro and go to LOAD_A; start while busy SHALL be ignored.
REQ-011 IDLE: start=1 with an invalid opcode (0000..0010, 1101..1111) SHALL go to ERR with no memory access; ERR SHALL set erro, pulse finished for 1 cycle, then return to IDLE.
REQ-012 LOAD_x SHALL last exactly 26 cycles: cycles 0..24 drive mem_addr=base_x+k; cycles 1..25 capture mem_rdata into element k-1 of the A or B register.
REQ-013 LOAD_B SHALL run only for binary opcodes 0011, 0100 and 0101; all other opcodes SHALL go from LOAD_A to EXEC.
REQ-014 alu_matrizA and alu_matrizB SHALL be driven from registers only; alu_escalar SHALL equal the latched escalar; alu_opcode SHALL be 0000 in every state except EXEC.
REQ-015 EXEC SHALL drive the latched opcode and SHALL ignore alu_done in its first cycle (stale done).
REQ-016 From the second EXEC cycle on, the first cycle with alu_done=1 SHALL capture alu_resultado into the C register and go to STORE.
REQ-017 A 256-cycle EXEC timeout without alu_done SHALL go to ERR; nothing SHALL be written to memory.
REQ-018 STORE SHALL drive mem_we=1, mem_addr=base_c+k and mem_wdata=element k for k=0..24 (25 cycles) in full-matrix modes; determinant opcodes 1001..1100 SHALL write element 0 only (1 cycle).
REQ-019 DONE SHALL pulse finished for 1 cycle, clear busy and return to IDLE.
REQ-020 Soma latency with an ALU that responds in 1 cycle: finished SHALL be high exactly 80 cycles after the edge that sampled start (26+26+2+25+1).
REQ-021 mem_we SHALL be 0 in every state except STORE.

Reset
REQ-022 reset SHALL immediately force IDLE, including mid-operation, with no pending write completed.
REQ-023 During reset, busy, finished, erro and mem_we SHALL be 0; alu_opcode SHALL be 0000; mem_addr, mem_wdata, the A/B/C registers and all counters SHALL be 0.

Structure
REQ-024 Package matriz_pkg SHALL hold N=5, ELEM_W=8, MAT_W=200, the opcode constants (SOMA=0011 .. DET5=1100) and the state encoding.
REQ-025 One sub-module, matriz_sequenciador, SHALL provide the 0..25 element counter with base-address generation (modulo 256) and the last-element flag, reused by the LOAD and STORE states.

Verification
REQ-026 Soma: A[k]=k, B[k]=2k at base_a=0x00, base_b=0x20, base_c=0x40 -> mem[0x40+k]=3k, and finished at cycle 80.
REQ-027 Transposta (0110): A[k]=k -> no reads at base_b, and mem[0x40+5j+i]=A(i,j) as returned by the model ALU.
REQ-028 DET2 (1001): model ALU returns 0x05 in byte 0 -> exactly one write (mem[0x40]=0x05, mem_we high 1 cycle).
REQ-029 Opcode 1111 -> finished 1 cycle after start, erro=1, no mem_we, no mem_addr activity beyond reset value.
REQ-030 Model ALU holds alu_done=1 at EXEC entry, then 0 for 300 cycles -> stale done ignored, timeout -> erro=1, no write.
REQ-031 reset pulsed in STORE at k=10 with base_c=0xFC -> mem_we drops at once, busy=0; writes made so far to 0xFC..0xFF and 0x00..0x05 show correct wrap-around.

Source files
------------

// File: rtl/matriz_pkg.sv
// Shared constants, opcodes and FSM encoding for the 5x5 matrix controller.
// Matrices are packed row-major, element (i,j) at bits 8*(5i+j).
package matriz_pkg;

  localparam int N        = 5;
  localparam int ELEM_W   = 8;
  localparam int NUM_ELEM = N * N;
  localparam int MAT_W    = NUM_ELEM * ELEM_W;
  localparam int IDX_W    = 5;
  localparam int ADDR_W   = 8;

  localparam logic [3:0] OP_SOMA          = 4'b0011;
  localparam logic [3:0] OP_SUBTRACAO     = 4'b0100;
  localparam logic [3:0] OP_MULTIPLICACAO = 4'b0101;
  localparam logic [3:0] OP_TRANSPOSTA    = 4'b0110;
  localparam logic [3:0] OP_OPOSTA        = 4'b0111;
  localparam logic [3:0] OP_ESCALAR       = 4'b1000;
  localparam logic [3:0] OP_DET2          = 4'b1001;
  localparam logic [3:0] OP_DET3          = 4'b1010;
  localparam logic [3:0] OP_DET4          = 4'b1011;
  localparam logic [3:0] OP_DET5          = 4'b1100;

  // LOAD spans idx 0..25 (address phase 0..24, capture phase 1..25).
  localparam logic [IDX_W-1:0] LOAD_ULTIMO  = 5'd25;
  localparam logic [IDX_W-1:0] STORE_ULTIMO = 5'd24;
  localparam logic [7:0]       EXEC_TIMEOUT = 8'd255;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadA = 3'd1,
    StLoadB = 3'd2,
    StExec  = 3'd3,
    StStore = 3'd4,
    StDone  = 3'd5,
    StErr   = 3'd6
  } estado_e;

  function automatic logic op_valido(input logic [3:0] op);
    return (op >= OP_SOMA) && (op <= OP_DET5);
  endfunction

  function automatic logic op_binario(input logic [3:0] op);
    return (op == OP_SOMA) || (op == OP_SUBTRACAO) || (op == OP_MULTIPLICACAO);
  endfunction

  function automatic logic op_det(input logic [3:0] op);
    return (op >= OP_DET2) && (op <= OP_DET5);
  endfunction

endpackage

// File: rtl/matriz_sequenciador.sv
// Element counter shared by the LOAD and STORE phases: walks idx from 0,
// produces base+idx modulo 256 and flags the last index of the phase.
module matriz_sequenciador
  import matriz_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [ADDR_W-1:0] base,
  input  logic [IDX_W-1:0]  limite,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic              ultimo
);

  logic [IDX_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 5'd1;
    end
  end

  always_comb begin
    idx    = cnt_q;
    // 8-bit add wraps naturally past 0xFF
    addr   = base + {{(ADDR_W - IDX_W){1'b0}}, cnt_q};
    ultimo = (cnt_q == limite);
  end

endmodule

// File: rtl/matriz_controlador.sv
// Matrix instruction controller: loads A/B from memory, runs the external ALU
// with a timeout, then writes the result matrix (or determinant) back.
module matriz_controlador
  import matriz_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [7:0]        escalar,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic              busy,
  output logic              finished,
  output logic              erro,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic [3:0]        alu_opcode,
  output logic [7:0]        alu_escalar,
  output logic [MAT_W-1:0]  alu_matrizA,
  output logic [MAT_W-1:0]  alu_matrizB,
  input  logic [MAT_W-1:0]  alu_resultado,
  input  logic              alu_done
);

  estado_e           state_q, state_d;
  logic [3:0]        op_q;
  logic [7:0]        esc_q;
  logic [ADDR_W-1:0] ba_q, bb_q, bc_q;
  logic [MAT_W-1:0]  a_q, b_q, c_q;
  logic [7:0]        exec_cnt_q;
  logic              busy_q, busy_d;
  logic              erro_q, erro_d;

  logic              seq_clr, seq_en, seq_ultimo;
  logic [ADDR_W-1:0] seq_base, seq_addr;
  logic [IDX_W-1:0]  seq_lim, seq_idx, cap_idx;
  logic              accept, cap_a, cap_b, cap_c;

  matriz_sequenciador u_seq (
    .clk    (clk),
    .reset  (reset),
    .clr    (seq_clr),
    .en     (seq_en),
    .base   (seq_base),
    .limite (seq_lim),
    .idx    (seq_idx),
    .addr   (seq_addr),
    .ultimo (seq_ultimo)
  );

  always_comb begin
    state_d    = state_q;
    seq_clr    = 1'b1;
    seq_en     = 1'b0;
    seq_base   = '0;
    seq_lim    = LOAD_ULTIMO;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    finished   = 1'b0;
    alu_opcode = 4'b0000;
    accept     = 1'b0;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    cap_c      = 1'b0;
    cap_idx    = seq_idx - 5'd1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op_valido(opcode)) begin
            accept  = 1'b1;
            state_d = StLoadA;
          end else begin
            state_d = StErr;
          end
        end
      end
      StLoadA: begin
        seq_clr  = 1'b0;
        seq_en   = 1'b1;
        seq_base = ba_q;
        if (seq_idx != LOAD_ULTIMO) mem_addr = seq_addr;
        // Read data lags its address by one cycle
        cap_a = (seq_idx != '0);
        if (seq_ultimo) begin
          seq_clr = 1'b1;
          state_d = op_binario(op_q) ? StLoadB : StExec;
        end
      end
      StLoadB: begin
        seq_clr  = 1'b0;
        seq_en   = 1'b1;
        seq_base = bb_q;
        if (seq_idx != LOAD_ULTIMO) mem_addr = seq_addr;
        cap_b = (seq_idx != '0);
        if (seq_ultimo) begin
          seq_clr = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        alu_opcode = op_q;
        // A done seen on the first cycle belongs to a previous operation
        if ((exec_cnt_q != 8'd0) && alu_done) begin
          cap_c   = 1'b1;
          state_d = StStore;
        end else if (exec_cnt_q == EXEC_TIMEOUT) begin
          state_d = StErr;
        end
      end
      StStore: begin
        seq_clr   = 1'b0;
        seq_en    = 1'b1;
        seq_base  = bc_q;
        seq_lim   = op_det(op_q) ? 5'd0 : STORE_ULTIMO;
        mem_we    = 1'b1;
        mem_addr  = seq_addr;
        mem_wdata = c_q[ELEM_W*int'(seq_idx) +: ELEM_W];
        if (seq_ultimo) begin
          seq_clr = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        finished = 1'b1;
        state_d  = StIdle;
      end
      StErr: begin
        finished = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = busy_q;
    erro_d = erro_q;
    if (accept) begin
      busy_d = 1'b1;
      erro_d = 1'b0;
    end
    if (state_d == StErr)  erro_d = 1'b1;
    if (state_d == StIdle) busy_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      esc_q      <= '0;
      ba_q       <= '0;
      bb_q       <= '0;
      bc_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      exec_cnt_q <= '0;
      busy_q     <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      erro_q  <= erro_d;
      if (accept) begin
        op_q  <= opcode;
        esc_q <= escalar;
        ba_q  <= base_a;
        bb_q  <= base_b;
        bc_q  <= base_c;
      end
      if (cap_a) a_q[ELEM_W*int'(cap_idx) +: ELEM_W] <= mem_rdata;
      if (cap_b) b_q[ELEM_W*int'(cap_idx) +: ELEM_W] <= mem_rdata;
      if (cap_c) c_q <= alu_resultado;
      exec_cnt_q <= (state_q == StExec) ? exec_cnt_q + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    busy        = busy_q;
    erro        = erro_q;
    alu_escalar = esc_q;
    alu_matrizA = a_q;
    alu_matrizB = b_q;
  end

endmodule

// File: tb/tb_matriz_controlador.sv
// Self-checking bench: behavioural memory and ALU models, write scoreboard,
// latency and error-path checks for matriz_controlador.
module tb_matriz_controlador;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   opcode;
  logic [7:0]   escalar, base_a, base_b, base_c;
  logic         busy, finished, erro;
  logic [7:0]   mem_addr, mem_rdata, mem_wdata;
  logic         mem_we;
  logic [3:0]   alu_opcode;
  logic [7:0]   alu_escalar;
  logic [199:0] alu_matrizA, alu_matrizB, alu_resultado;
  logic         alu_done;

  always #5 clk = ~clk;

  matriz_controlador dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .opcode        (opcode),
    .escalar       (escalar),
    .base_a        (base_a),
    .base_b        (base_b),
    .base_c        (base_c),
    .busy          (busy),
    .finished      (finished),
    .erro          (erro),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .alu_opcode    (alu_opcode),
    .alu_escalar   (alu_escalar),
    .alu_matrizA   (alu_matrizA),
    .alu_matrizB   (alu_matrizB),
    .alu_resultado (alu_resultado),
    .alu_done      (alu_done)
  );

  // Memory model: synchronous read, bench-side preload port
  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = 8'h00, tb_data = 8'h00;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
    mem_rdata <= mem[mem_addr];
  end

  // ALU model: mode 1 answers one cycle after seeing an opcode,
  // mode 2 raises done only while idle (stale done, then silence)
  int alu_mode = 1;

  always @(posedge clk) begin
    if (alu_mode == 2) alu_done <= (alu_opcode == 4'd0);
    else               alu_done <= (alu_opcode != 4'd0);
  end

  function automatic logic [199:0] alu_model(input logic [3:0] op, input logic [199:0] a,
                                             input logic [199:0] b);
    logic [199:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        case (op)
          4'd3: r[8*(5*i+j) +: 8] = a[8*(5*i+j) +: 8] + b[8*(5*i+j) +: 8];
          4'd6: r[8*(5*i+j) +: 8] = a[8*(5*j+i) +: 8];
          4'd7: r[8*(5*i+j) +: 8] = -a[8*(5*i+j) +: 8];
          default: ;
        endcase
      end
    end
    if (op == 4'd9) r[7:0] = 8'h05;
    return r;
  endfunction

  always_comb alu_resultado = alu_model(alu_opcode, alu_matrizA, alu_matrizB);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write scoreboard and bus activity monitors
  logic [15:0] exp_q [$];
  int wr_cnt, extra_wr, rd_b, addr_act;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (mem_we === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) extra_wr++;
        else check_eq("wr", 32'({mem_addr, mem_wdata}), 32'(exp_q.pop_front()));
      end
      if (mem_we !== 1'b1 && mem_addr >= 8'h20 && mem_addr <= 8'h38) rd_b++;
      if (mem_addr !== 8'h00) addr_act++;
    end
  end

  function automatic logic op_ok(input logic [3:0] op);
    return (op >= 4'd3) && (op <= 4'd12);
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic clear_mon();
    wr_cnt = 0; extra_wr = 0; rd_b = 0; addr_act = 0;
  endtask

  // lat = number of edges after the sampling edge until finished is seen
  task automatic run_op(input logic [3:0] op, input logic [7:0] ba, input logic [7:0] bb,
                        input logic [7:0] bc, input int budget, output int lat);
    @(negedge clk);
    opcode = op; base_a = ba; base_b = bb; base_c = bc; escalar = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check_eq("busy_at_start", 32'(busy), 32'(op_ok(op)));
    check_eq("erro_at_start", 32'(erro), 32'(!op_ok(op)));
    while (finished !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    check_eq("finished_seen", 32'(finished), 32'd1);
    @(negedge clk);
    check_eq("finished_pulse", 32'(finished), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  int lat;
  logic found;

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 4'd0; escalar = 8'd0;
    base_a = 8'd0; base_b = 8'd0; base_c = 8'd0;
    clear_mon();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_finished", 32'(finished), 32'd0);
    check_eq("rst_erro", 32'(erro), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_aluop", 32'(alu_opcode), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_matA", 32'(|alu_matrizA), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 25; k++) begin
      poke(8'(k), 8'(k));
      poke(8'(8'h20 + k), 8'(2 * k));
    end

    // Soma
    clear_mon();
    for (int k = 0; k < 25; k++) exp_q.push_back({8'(8'h40 + k), 8'(3 * k)});
    run_op(4'b0011, 8'h00, 8'h20, 8'h40, 500, lat);
    check_eq("soma_latency", 32'(lat), 32'd80);
    check_eq("soma_sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("soma_extra_wr", 32'(extra_wr), 32'd0);
    check_eq("soma_erro", 32'(erro), 32'd0);
    check_eq("soma_busy_after", 32'(busy), 32'd0);
    check_eq("soma_escalar", 32'(alu_escalar), 32'h03);

    // Transposta: no B fetch, mem[0x40+5j+i] = A(i,j) = 5i+j
    clear_mon();
    for (int m = 0; m < 25; m++) exp_q.push_back({8'(8'h40 + m), 8'(5 * (m % 5) + m / 5)});
    run_op(4'b0110, 8'h00, 8'h20, 8'h40, 500, lat);
    check_eq("transp_latency", 32'(lat), 32'd54);
    check_eq("transp_reads_b", 32'(rd_b), 32'd0);
    check_eq("transp_sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("transp_extra_wr", 32'(extra_wr), 32'd0);

    // DET2: single write of byte 0
    clear_mon();
    exp_q.push_back({8'h40, 8'h05});
    run_op(4'b1001, 8'h00, 8'h20, 8'h40, 500, lat);
    check_eq("det2_latency", 32'(lat), 32'd30);
    check_eq("det2_wr_cycles", 32'(wr_cnt), 32'd1);
    check_eq("det2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Invalid opcode
    clear_mon();
    run_op(4'b1111, 8'h00, 8'h20, 8'h40, 50, lat);
    check_eq("inval_latency", 32'(lat), 32'd1);
    check_eq("inval_erro", 32'(erro), 32'd1);
    check_eq("inval_wr", 32'(wr_cnt), 32'd0);
    check_eq("inval_addr_act", 32'(addr_act), 32'd0);

    // Stale done then silence: timeout into ERR, no write
    clear_mon();
    alu_mode = 2;
    run_op(4'b0111, 8'h00, 8'h20, 8'h40, 1000, lat);
    alu_mode = 1;
    check_eq("tmo_latency", 32'(lat), 32'd283);
    check_eq("tmo_erro", 32'(erro), 32'd1);
    check_eq("tmo_wr", 32'(wr_cnt), 32'd0);

    // Reset during STORE at k=10, base_c=0xFC wraps to 0x00
    clear_mon();
    for (int k = 0; k < 10; k++) exp_q.push_back({8'(8'hFC + k), 8'(3 * k)});
    @(negedge clk);
    opcode = 4'b0011; base_a = 8'h00; base_b = 8'h20; base_c = 8'hFC; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("wrap_erro_cleared", 32'(erro), 32'd0);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk);
      #1;
      if (mem_we === 1'b1 && mem_addr === 8'h06) found = 1'b1;
    end
    check_eq("wrap_k10_reached", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("wrap_we_drop", 32'(mem_we), 32'd0);
    check_eq("wrap_busy_drop", 32'(busy), 32'd0);
    check_eq("wrap_aluop", 32'(alu_opcode), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("wrap_matA_clr", 32'(|alu_matrizA), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("wrap_extra_wr", 32'(extra_wr), 32'd0);
    for (int k = 0; k < 10; k++) check_eq("wrap_mem", 32'(mem[8'(8'hFC + k)]), 32'(3 * k));
    check_eq("wrap_mem06_kept", 32'(mem[8'h06]), 32'h06);
    check_eq("wrap_idle_finished", 32'(finished), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
